bus_transfer_sequencer: RTL and testbench

//  Initiator side of the 8-bit bus-control interface. Accepts queued register-transfer

---
 rtl/bus_transfer_sequencer_pkg.sv | 40 ++++
 rtl/bus_transfer_sequencer_transfer_fifo.sv | 65 ++++++
 rtl/bus_transfer_sequencer.sv | 137 +++++++++++++
 tb/tb_bus_transfer_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_transfer_sequencer_pkg.sv
// Shared types for the bus-transfer sequencer: device codes, FSM states, request layout.
package bus_transfer_sequencer_pkg;

   localparam logic [4:0] DEV_NONE  = 5'd0;
   localparam logic [4:0] DEV_CONST = 5'd1;
   localparam logic [4:0] DEV_A     = 5'd2;
   localparam logic [4:0] DEV_B     = 5'd3;
   localparam logic [4:0] DEV_C     = 5'd4;
   localparam logic [4:0] DEV_D     = 5'd5;

   localparam int unsigned REQ_W = 19;

   typedef enum logic [2:0] {
      StIdle,
      StKSetup,
      StKLoad,
      StSetup,
      StLoad,
      StHold
   } state_e;

   typedef struct packed {
      logic       imm;
      logic [4:0] src;
      logic [4:0] dst;
      logic [7:0] data;
   } req_t;

   function automatic logic req_valid(input req_t r, input logic [4:0] max_code);
      logic ok;
      ok = (r.dst != DEV_NONE) && (r.dst <= max_code);
      if (r.imm) begin
         ok = ok && (r.dst != DEV_CONST);
      end else begin
         ok = ok && (r.src != DEV_NONE) && (r.src <= max_code) && (r.src != r.dst);
      end
      return ok;
   endfunction

endpackage

// File: rtl/bus_transfer_sequencer_transfer_fifo.sv
// First-word-fall-through request queue with synchronous reset.
module transfer_fifo
   import bus_transfer_sequencer_pkg::*;
#(
   parameter int unsigned Width = REQ_W,
   parameter int unsigned Depth = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [Width-1:0] i_wdata,
   input  logic             i_pop,
   output logic [Width-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW  = $clog2(Depth + 1);
   localparam logic [AddrW-1:0] PtrOne  = AddrW'(1);
   localparam logic [CntW-1:0]  CntOne  = CntW'(1);
   localparam logic [CntW-1:0]  CntFull = CntW'(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign o_full  = (cnt_q == CntFull);
   assign o_empty = (cnt_q == '0);
   assign do_push = i_push & ~o_full;
   assign do_pop  = i_pop & ~o_empty;
   assign o_rdata = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      if (do_push && !do_pop) begin
         cnt_d = cnt_q + CntOne;
      end else if (!do_push && do_pop) begin
         cnt_d = cnt_q - CntOne;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: the count gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= i_wdata;
   end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Sequences queued register moves / immediate loads into registered bus-control words.
module bus_transfer_sequencer
   import bus_transfer_sequencer_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned MAX_CODE   = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_req_valid,
   output logic       o_req_ready,
   input  logic       i_req_imm,
   input  logic [4:0] i_req_src,
   input  logic [4:0] i_req_dst,
   input  logic [7:0] i_req_data,
   output logic [4:0] o_8bit_assert_word,
   output logic [4:0] o_8bit_load_word,
   output logic [7:0] o_bus_in,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_err
);

   localparam logic [4:0] MaxCode = 5'(MAX_CODE);

   req_t       push_req, head_req;
   logic       fifo_full, fifo_empty, pop, try_pop;
   state_e     state_q, state_d;
   logic [4:0] src_q, src_d, dst_q, dst_d;
   logic [4:0] assert_q, assert_d, load_q, load_d;
   logic [7:0] bus_q, bus_d;
   logic       done_q, done_d, err_q, err_d;

   assign push_req = {i_req_imm, i_req_src, i_req_dst, i_req_data};

   transfer_fifo #(
      .Width (REQ_W),
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (i_req_valid),
      .i_wdata (push_req),
      .i_pop   (pop),
      .o_rdata (head_req),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

   // Each arm computes the words shown while sitting in the *next* state.
   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      dst_d    = dst_q;
      assert_d = DEV_NONE;
      load_d   = DEV_NONE;
      bus_d    = bus_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      try_pop  = 1'b0;
      unique case (state_q)
         StIdle:   try_pop = 1'b1;
         StKSetup: begin
            state_d = StKLoad;
            load_d  = DEV_CONST;
         end
         StKLoad: begin
            state_d  = StSetup;
            assert_d = src_q;
         end
         StSetup: begin
            state_d  = StLoad;
            assert_d = src_q;
            load_d   = dst_q;
         end
         StLoad: begin
            state_d  = StHold;
            assert_d = src_q;
            done_d   = 1'b1;
         end
         StHold: begin
            state_d = StIdle;
            try_pop = 1'b1;
         end
         default: state_d = StIdle;
      endcase

      pop = try_pop & ~fifo_empty;
      if (pop) begin
         if (!req_valid(head_req, MaxCode)) begin
            state_d = StIdle;
            err_d   = 1'b1;
         end else if (head_req.imm) begin
            state_d = StKSetup;
            src_d   = DEV_CONST;
            dst_d   = head_req.dst;
            bus_d   = head_req.data;
         end else begin
            state_d  = StSetup;
            src_d    = head_req.src;
            dst_d    = head_req.dst;
            assert_d = head_req.src;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         src_q    <= DEV_NONE;
         dst_q    <= DEV_NONE;
         assert_q <= DEV_NONE;
         load_q   <= DEV_NONE;
         bus_q    <= 8'h00;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         assert_q <= assert_d;
         load_q   <= load_d;
         bus_q    <= bus_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign o_req_ready        = ~fifo_full;
   assign o_8bit_assert_word = assert_q;
   assign o_8bit_load_word   = load_q;
   assign o_bus_in           = bus_q;
   assign o_busy             = (state_q != StIdle) || !fifo_empty;
   assign o_done             = done_q;
   assign o_err              = err_q;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Scoreboard bench: expected load words and done/err events are queued at push time.
module tb_bus_transfer_sequencer;

   localparam int unsigned FifoDepth = 4;
   localparam int unsigned MaxCode   = 5;

   typedef struct packed {
      logic [4:0] asrt;
      logic [4:0] ld;
      logic [7:0] bus;
   } ld_rec_t;

   typedef enum logic [1:0] {EvDone = 2'b10, EvErr = 2'b01} ev_e;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i_req_valid = 1'b0;
   logic       o_req_ready;
   logic       i_req_imm = 1'b0;
   logic [4:0] i_req_src = '0;
   logic [4:0] i_req_dst = '0;
   logic [7:0] i_req_data = '0;
   logic [4:0] o_8bit_assert_word;
   logic [4:0] o_8bit_load_word;
   logic [7:0] o_bus_in;
   logic       o_busy, o_done, o_err;

   ld_rec_t     exp_ld[$];
   ev_e         exp_evt[$];
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned cyc = 0;
   int unsigned err_seen = 0;
   int unsigned gap_prev = 0;
   logic        prev_load = 1'b0;
   logic        gap_en = 1'b0;
   logic        gap_prev_ok = 1'b0;
   logic [7:0]  bus_model = 8'h00;

   logic [4:0] t2_ld [3];
   logic [4:0] t3_as [5];
   logic [4:0] t3_ld [5];
   logic [4:0] t5_src [6];
   logic [4:0] t5_dst [6];

   bus_transfer_sequencer #(
      .FIFO_DEPTH (FifoDepth),
      .MAX_CODE   (MaxCode)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .i_req_valid        (i_req_valid),
      .o_req_ready        (o_req_ready),
      .i_req_imm          (i_req_imm),
      .i_req_src          (i_req_src),
      .i_req_dst          (i_req_dst),
      .i_req_data         (i_req_data),
      .o_8bit_assert_word (o_8bit_assert_word),
      .o_8bit_load_word   (o_8bit_load_word),
      .o_bus_in           (o_bus_in),
      .o_busy             (o_busy),
      .o_done             (o_done),
      .o_err              (o_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic model_ok(input logic imm, input logic [4:0] src,
                                     input logic [4:0] dst);
      int s, d;
      s = int'(src);
      d = int'(dst);
      if (d == 0 || d > int'(MaxCode)) return 1'b0;
      if (imm) return (d != 1);
      return (s != 0) && (s <= int'(MaxCode)) && (s != d);
   endfunction

   task automatic push_req(input logic imm, input logic [4:0] src, input logic [4:0] dst,
                           input logic [7:0] data);
      int unsigned waitc = 0;
      @(negedge clk);
      while (!o_req_ready && waitc < 50) begin
         @(negedge clk);
         waitc++;
      end
      if (!o_req_ready) begin
         check_eq("push_ready_timeout", 32'(o_req_ready), 32'd1);
      end else begin
         i_req_valid = 1'b1;
         i_req_imm   = imm;
         i_req_src   = src;
         i_req_dst   = dst;
         i_req_data  = data;
         if (!model_ok(imm, src, dst)) begin
            exp_evt.push_back(EvErr);
         end else begin
            if (imm) begin
               bus_model = data;
               exp_ld.push_back('{asrt: 5'd0, ld: 5'd1, bus: data});
               exp_ld.push_back('{asrt: 5'd1, ld: dst, bus: data});
            end else begin
               exp_ld.push_back('{asrt: src, ld: dst, bus: bus_model});
            end
            exp_evt.push_back(EvDone);
         end
         @(posedge clk);
         #1;
         i_req_valid = 1'b0;
      end
   endtask

   task automatic wait_idle(input string tag);
      int unsigned n = 0;
      @(negedge clk);
      while (o_busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_idle"}, 32'(o_busy), 32'd0);
      repeat (2) @(negedge clk);
      check_eq({tag, "_sb_drained"}, 32'(exp_ld.size() + exp_evt.size()), 32'd0);
   endtask

   // Output monitor: every load pulse and every done/err pulse must match the scoreboard.
   initial begin
      ld_rec_t r;
      ev_e     e;
      forever begin
         @(negedge clk);
         cyc++;
         if (o_8bit_load_word != 5'd0) begin
            check_eq("ld_not_b2b", 32'(prev_load), 32'd0);
            if (exp_ld.size() == 0) begin
               check_eq("ld_unexpected", 32'(o_8bit_load_word), 32'd0);
            end else begin
               r = exp_ld.pop_front();
               check_eq("ld_words", 32'({o_8bit_assert_word, o_8bit_load_word, o_bus_in}),
                        32'(r));
            end
            if (gap_en) begin
               if (gap_prev_ok) check_eq("hold_setup_gap", cyc - gap_prev, 32'd3);
               gap_prev    = cyc;
               gap_prev_ok = 1'b1;
            end
         end
         prev_load = (o_8bit_load_word != 5'd0);
         if (o_err == 1'b1) err_seen++;
         if (o_done == 1'b1 || o_err == 1'b1) begin
            if (exp_evt.size() == 0) begin
               check_eq("ev_unexpected", 32'({o_done, o_err}), 32'd0);
            end else begin
               e = exp_evt.pop_front();
               check_eq("ev_done_err", 32'({o_done, o_err}), 32'(e));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int unsigned e0;
      logic [4:0]  rs, rd;
      t2_ld  = '{5'd0, 5'd3, 5'd0};
      t3_as  = '{5'd0, 5'd0, 5'd1, 5'd1, 5'd1};
      t3_ld  = '{5'd0, 5'd1, 5'd0, 5'd4, 5'd0};
      t5_src = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd2, 5'd3};
      t5_dst = '{5'd3, 5'd4, 5'd5, 5'd2, 5'd4, 5'd5};

      // Reset held for two edges
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_assert", 32'(o_8bit_assert_word), 32'd0);
      check_eq("rst_load", 32'(o_8bit_load_word), 32'd0);
      check_eq("rst_bus", 32'(o_bus_in), 32'd0);
      check_eq("rst_ready", 32'(o_req_ready), 32'd1);
      check_eq("rst_busy", 32'(o_busy), 32'd0);
      check_eq("rst_done", 32'(o_done), 32'd0);
      check_eq("rst_err", 32'(o_err), 32'd0);
      rst = 1'b0;

      // Move A->B
      push_req(1'b0, 5'd2, 5'd3, 8'h00);
      @(negedge clk);
      check_eq("t2_latency_assert", 32'(o_8bit_assert_word), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("t2_assert", 32'(o_8bit_assert_word), 32'd2);
         check_eq("t2_load", 32'(o_8bit_load_word), 32'(t2_ld[i]));
         check_eq("t2_done", 32'(o_done), (i == 2) ? 32'd1 : 32'd0);
      end
      wait_idle("t2");

      // Immediate 0x5A into C
      push_req(1'b1, 5'd0, 5'd4, 8'h5A);
      @(negedge clk);
      check_eq("t3_bus_before", 32'(o_bus_in), 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("t3_assert", 32'(o_8bit_assert_word), 32'(t3_as[i]));
         check_eq("t3_load", 32'(o_8bit_load_word), 32'(t3_ld[i]));
         check_eq("t3_bus", 32'(o_bus_in), 32'h5A);
         check_eq("t3_done", 32'(o_done), (i == 4) ? 32'd1 : 32'd0);
      end
      wait_idle("t3");

      // Two invalid requests
      e0 = err_seen;
      push_req(1'b0, 5'd2, 5'd2, 8'h00);
      push_req(1'b1, 5'd0, 5'd1, 8'h33);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("t4_assert", 32'(o_8bit_assert_word), 32'd0);
         check_eq("t4_load", 32'(o_8bit_load_word), 32'd0);
      end
      wait_idle("t4");
      check_eq("t4_err_count", err_seen - e0, 32'd2);
      check_eq("t4_bus_held", 32'(o_bus_in), 32'h5A);

      // Six back-to-back moves fill the queue and chain HOLD->SETUP
      gap_en      = 1'b1;
      gap_prev_ok = 1'b0;
      for (int i = 0; i < 6; i++) push_req(1'b0, t5_src[i], t5_dst[i], 8'h00);
      @(negedge clk);
      check_eq("t5_ready_full", 32'(o_req_ready), 32'd0);
      wait_idle("t5");
      gap_en = 1'b0;

      // Reset while a move is in LOAD with two requests queued
      push_req(1'b0, 5'd2, 5'd3, 8'h00);
      push_req(1'b0, 5'd3, 5'd4, 8'h00);
      push_req(1'b0, 5'd4, 5'd5, 8'h00);
      @(negedge clk);
      check_eq("t6_in_load", 32'(o_8bit_load_word), 32'd3);
      #1;
      rst = 1'b1;
      exp_ld.delete();
      exp_evt.delete();
      bus_model = 8'h00;
      @(negedge clk);
      check_eq("t6_assert", 32'(o_8bit_assert_word), 32'd0);
      check_eq("t6_load", 32'(o_8bit_load_word), 32'd0);
      check_eq("t6_done", 32'(o_done), 32'd0);
      check_eq("t6_busy", 32'(o_busy), 32'd0);
      check_eq("t6_ready", 32'(o_req_ready), 32'd1);
      check_eq("t6_bus", 32'(o_bus_in), 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("t6_stays_idle", 32'(o_busy), 32'd0);
      push_req(1'b0, 5'd5, 5'd2, 8'h00);
      wait_idle("t6_recover");

      // Random mix of valid and invalid requests
      for (int i = 0; i < 16; i++) begin
         rs = 5'($urandom_range(0, 6));
         rd = 5'($urandom_range(0, 6));
         push_req(1'($urandom_range(0, 1)), rs, rd, 8'($urandom_range(0, 255)));
      end
      wait_idle("rand");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
